// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file with two combinational read ports, one write port, an
//   optional same-cycle write-to-read bypass, and a per-register busy
//   scoreboard. Decode reserves a destination; writeback clears it.
//
//   Parameters : DATA_W (register width), ADDR_W (NREGS = 2**ADDR_W),
//                BYPASS (1 = forward same-cycle write data to reads)
//   Ports      : clock, ctrl_reset (sync, active high)
//                write  : ctrl_writeEnable, ctrl_writeReg, data_writeReg
//                read   : ctrl_readRegA/B -> data_readRegA/B, busy_readRegA/B
//                reserve: ctrl_reserveEnable, ctrl_reserveReg -> reserve_grant
//                busy_count : number of registers currently busy
//   r0 is hardwired to zero and is never busy.

// One register plus its busy bit. Reservation beats a same-cycle write so the
// register stays busy when a new producer issues in the writeback cycle.
module regfile_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              wr_hit,
  input  logic              rsv_hit,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data,
  output logic              busy
);
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      data <= '0;
      busy <= 1'b0;
    end else begin
      if (wr_hit) data <= wdata;
      if (rsv_hit)     busy <= 1'b1;
      else if (wr_hit) busy <= 1'b0;
    end
  end
endmodule

module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  input  logic              ctrl_reserveEnable,
  input  logic [ADDR_W-1:0] ctrl_reserveReg,
  output logic              reserve_grant,
  output logic              busy_readRegA,
  output logic              busy_readRegB,
  output logic [ADDR_W:0]   busy_count
);
  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0]             busy;
  logic [NREGS-1:0]             wr_hit;
  logic [NREGS-1:0]             busy_eff;
  logic                         wr_valid;
  logic                         rsv_nz;
  logic                         cnt_inc;
  logic                         cnt_dec;

  // Writes to r0 are dropped at the decode, so r0 never sees a hit.
  assign wr_valid = ctrl_writeEnable && (ctrl_writeReg != '0);
  assign rsv_nz   = ctrl_reserveReg != '0;

  always_comb begin
    wr_hit = '0;
    if (wr_valid) wr_hit[ctrl_writeReg] = 1'b1;
  end

  // Busy as seen after this cycle's writeback clear.
  assign busy_eff = busy & ~wr_hit;

  assign reserve_grant = ctrl_reserveEnable && (!rsv_nz || !busy_eff[ctrl_reserveReg]);

  // r0: constant zero, never busy.
  assign regs[0] = '0;
  assign busy[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_cell
    logic rsv_hit;
    assign rsv_hit = reserve_grant && (ctrl_reserveReg == ADDR_W'(i));
    regfile_cell #(.DATA_W(DATA_W)) u_cell (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .wr_hit     (wr_hit[i]),
      .rsv_hit    (rsv_hit),
      .wdata      (data_writeReg),
      .data       (regs[i]),
      .busy       (busy[i])
    );
  end

  // Read ports. Bypass only forwards nonzero addresses because wr_valid
  // already excludes r0.
  always_comb begin
    data_readRegA = regs[ctrl_readRegA];
    data_readRegB = regs[ctrl_readRegB];
    if (BYPASS != 0) begin
      if (wr_valid && (ctrl_writeReg == ctrl_readRegA)) data_readRegA = data_writeReg;
      if (wr_valid && (ctrl_writeReg == ctrl_readRegB)) data_readRegB = data_writeReg;
    end
  end

  // Clear-on-write masking applies whatever BYPASS is, so the hazard unit
  // can release a consumer in the writeback cycle itself.
  assign busy_readRegA = busy[ctrl_readRegA] &&
                         !(ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA));
  assign busy_readRegB = busy[ctrl_readRegB] &&
                         !(ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB));

  // The count tracks the population of busy bits: +1 for every bit that is
  // set, -1 for every set bit cleared. A write+reserve on the same busy
  // register does both and nets to zero.
  assign cnt_inc = reserve_grant && rsv_nz;
  assign cnt_dec = wr_valid && busy[ctrl_writeReg];

  always_ff @(posedge clock) begin
    if (ctrl_reset)               busy_count <= '0;
    else if (cnt_inc && !cnt_dec) busy_count <= busy_count + 1'b1;
    else if (cnt_dec && !cnt_inc) busy_count <= busy_count - 1'b1;
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard. Two instances share inputs:
// dut (BYPASS=1) is checked on every output, dut_nb (BYPASS=0) on read port A.
// Each cycle's expected outputs are queued when the stimulus is driven and
// popped when the outputs are sampled on the falling edge.
module tb_regfile_scoreboard;
  logic        clock = 1'b0;
  logic        ctrl_reset, ctrl_writeEnable, ctrl_reserveEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, ctrl_reserveReg;
  logic [31:0] data_writeReg;
  logic [31:0] data_readRegA, data_readRegB, nb_readRegA, nb_readRegB;
  logic        reserve_grant, busy_readRegA, busy_readRegB;
  logic        nb_grant, nb_busyA, nb_busyB;
  logic [5:0]  busy_count, nb_count;

  always #5 clock = ~clock;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .ctrl_reserveEnable(ctrl_reserveEnable), .ctrl_reserveReg(ctrl_reserveReg),
    .reserve_grant(reserve_grant),
    .busy_readRegA(busy_readRegA), .busy_readRegB(busy_readRegB),
    .busy_count(busy_count));

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(nb_readRegA), .data_readRegB(nb_readRegB),
    .ctrl_reserveEnable(ctrl_reserveEnable), .ctrl_reserveReg(ctrl_reserveReg),
    .reserve_grant(nb_grant),
    .busy_readRegA(nb_busyA), .busy_readRegB(nb_busyB),
    .busy_count(nb_count));

  typedef struct {
    logic        rst, we;
    logic [4:0]  wreg;
    logic [31:0] wd;
    logic [4:0]  ra, rb;
    logic        re;
    logic [4:0]  rr;
    logic [31:0] ea, eb, ea_nb;
    logic        ba, bb, g;
    logic [5:0]  cnt;
  } vec_t;

  vec_t        exp_q[$];
  vec_t        vecs[24];
  logic [31:0] ref_mem[32];
  int          checks = 0;
  int          failures = 0;

  function automatic vec_t mk(logic rst, logic we, logic [4:0] wreg, logic [31:0] wd,
                              logic [4:0] ra, logic [4:0] rb, logic re, logic [4:0] rr,
                              logic [31:0] ea, logic [31:0] eb, logic [31:0] ea_nb,
                              logic ba, logic bb, logic g, logic [5:0] cnt);
    vec_t v;
    v.rst = rst; v.we = we; v.wreg = wreg; v.wd = wd; v.ra = ra; v.rb = rb;
    v.re = re; v.rr = rr; v.ea = ea; v.eb = eb; v.ea_nb = ea_nb;
    v.ba = ba; v.bb = bb; v.g = g; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle (called at posedge+1), compare on the falling edge,
  // then let the edge commit and update the bench's own memory image.
  task automatic run(input string tag, input vec_t v);
    vec_t e;
    ctrl_reset = v.rst; ctrl_writeEnable = v.we; ctrl_writeReg = v.wreg;
    data_writeReg = v.wd; ctrl_readRegA = v.ra; ctrl_readRegB = v.rb;
    ctrl_reserveEnable = v.re; ctrl_reserveReg = v.rr;
    exp_q.push_back(v);
    @(negedge clock);
    e = exp_q.pop_front();
    check({tag, ".rdA"},   data_readRegA, e.ea);
    check({tag, ".rdB"},   data_readRegB, e.eb);
    check({tag, ".nbA"},   nb_readRegA, e.ea_nb);
    check({tag, ".busyA"}, 32'(busy_readRegA), 32'(e.ba));
    check({tag, ".busyB"}, 32'(busy_readRegB), 32'(e.bb));
    check({tag, ".grant"}, 32'(reserve_grant), 32'(e.g));
    check({tag, ".count"}, 32'(busy_count), 32'(e.cnt));
    @(posedge clock);
    #1;
    if (v.rst) begin
      for (int k = 0; k < 32; k++) ref_mem[k] = '0;
    end else if (v.we && v.wreg != 0) begin
      ref_mem[v.wreg] = v.wd;
    end
  endtask

  // After reset every address reads 0 and nothing is busy.
  task automatic read_all_zero(input string tag);
    for (int j = 0; j < 32; j++)
      run($sformatf("%s_r%0d", tag, j),
          mk(0, 0, 0, 0, 5'(j), 5'(31 - j), 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    for (int k = 0; k < 32; k++) ref_mem[k] = '0;
    vecs[0]  = mk(0,1, 5,32'hDEADBEEF, 5, 5,0, 0, 32'hDEADBEEF,32'hDEADBEEF,32'h0,       0,0,0,0);
    vecs[1]  = mk(0,0, 0,32'h0,        5, 5,0, 0, 32'hDEADBEEF,32'hDEADBEEF,32'hDEADBEEF,0,0,0,0);
    vecs[2]  = mk(0,1, 0,32'h1234,     0, 5,0, 0, 32'h0,       32'hDEADBEEF,32'h0,       0,0,0,0);
    vecs[3]  = mk(0,0, 0,32'h0,        0, 0,0, 0, 32'h0,       32'h0,       32'h0,       0,0,0,0);
    vecs[4]  = mk(0,1, 7,32'hA5A5A5A5, 7, 7,0, 0, 32'hA5A5A5A5,32'hA5A5A5A5,32'h0,       0,0,0,0);
    vecs[5]  = mk(0,0, 0,32'h0,        7, 5,0, 0, 32'hA5A5A5A5,32'hDEADBEEF,32'hA5A5A5A5,0,0,0,0);
    vecs[6]  = mk(0,0, 0,32'h0,        3, 3,1, 3, 32'h0,       32'h0,       32'h0,       0,0,1,0);
    vecs[7]  = mk(0,0, 0,32'h0,        3, 0,1, 3, 32'h0,       32'h0,       32'h0,       1,0,0,1);
    vecs[8]  = mk(0,0, 0,32'h0,        3, 3,0, 0, 32'h0,       32'h0,       32'h0,       1,1,0,1);
    vecs[9]  = mk(0,1, 3,32'h33,       3, 3,0, 0, 32'h33,      32'h33,      32'h0,       0,0,0,1);
    vecs[10] = mk(0,0, 0,32'h0,        3, 3,0, 0, 32'h33,      32'h33,      32'h33,      0,0,0,0);
    vecs[11] = mk(0,0, 0,32'h0,        9, 9,1, 9, 32'h0,       32'h0,       32'h0,       0,0,1,0);
    vecs[12] = mk(0,1, 9,32'h99,       9, 9,1, 9, 32'h99,      32'h99,      32'h0,       0,0,1,1);
    vecs[13] = mk(0,0, 0,32'h0,        9, 9,0, 0, 32'h99,      32'h99,      32'h99,      1,1,0,1);
    vecs[14] = mk(0,1, 9,32'h9A,       9,10,1,10, 32'h9A,      32'h0,       32'h99,      0,0,1,1);
    vecs[15] = mk(0,0, 0,32'h0,        9,10,0, 0, 32'h9A,      32'h0,       32'h9A,      0,1,0,1);
    vecs[16] = mk(0,1, 5,32'h55,       5,10,0, 0, 32'h55,      32'h0,       32'hDEADBEEF,0,1,0,1);
    vecs[17] = mk(0,0, 0,32'h0,        0,10,1, 0, 32'h0,       32'h0,       32'h0,       0,1,1,1);
    vecs[18] = mk(0,0, 0,32'h0,        0,10,0, 0, 32'h0,       32'h0,       32'h0,       0,1,0,1);
    vecs[19] = mk(0,0, 0,32'h0,       10, 5,1,10, 32'h0,       32'h55,      32'h0,       1,0,0,1);
    vecs[20] = mk(0,1,10,32'hAA,      10,10,1,10, 32'hAA,      32'hAA,      32'h0,       0,0,1,1);
    vecs[21] = mk(0,0, 0,32'h0,       10, 5,0, 0, 32'hAA,      32'h55,      32'hAA,      1,0,0,1);
    vecs[22] = mk(0,1,10,32'hAB,      10,10,0, 0, 32'hAB,      32'hAB,      32'hAA,      0,0,0,1);
    vecs[23] = mk(0,0, 0,32'h0,       10, 9,0, 0, 32'hAB,      32'h9A,      32'hAB,      0,0,0,0);

    ctrl_reset = 1'b1; ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
    ctrl_readRegA = '0; ctrl_readRegB = '0; ctrl_reserveEnable = 1'b0; ctrl_reserveReg = '0;
    repeat (2) @(posedge clock);
    #1;

    read_all_zero("init");

    for (int i = 0; i < 24; i++) run($sformatf("vec%0d", i), vecs[i]);

    // Fill the scoreboard: every nonzero register reserved in turn.
    for (int i = 1; i < 32; i++)
      run($sformatf("fill%0d", i),
          mk(0, 0, 0, 0, 5'(i), 5'(i - 1), 1, 5'(i),
             ref_mem[i], ref_mem[i-1], ref_mem[i], 0, (i > 1), 1, 6'(i - 1)));
    run("full", mk(0, 0, 0, 0, 31, 1, 1, 4, ref_mem[31], ref_mem[1], ref_mem[31], 1, 1, 0, 31));

    // Reset with a concurrent write and reservation: both must be discarded.
    run("rst", mk(1, 1, 2, 32'h2222, 2, 5, 1, 4, 32'h2222, ref_mem[5], ref_mem[2], 0, 1, 0, 31));
    run("post_rst", mk(0, 0, 0, 0, 2, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    read_all_zero("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
